// File: rtl/seg7_pkg.sv
// Shared types and active-low segment codes ({g,f,e,d,c,b,a}) for the M100 scanner.
package seg7_pkg;

  typedef enum logic [1:0] {
    BLANK_U = 2'd0,
    SHOW_U  = 2'd1,
    BLANK_C = 2'd2,
    SHOW_C  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_m100.sv
// Two-digit multiplexed 7-segment scanner for a mod-100 BCD counter.
// Digits are captured once per frame so a frame never mixes old and new values.
module seg7_scan_m100
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4,
  parameter int LZ_BLANK  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] q_donvi,
  input  logic [3:0] q_chuc,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    units_q, units_d;
  logic [3:0]    tens_q, tens_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic [3:0]    digit_sel;
  logic [6:0]    seg_dec;

  // Single shared decoder; the state picks which latched digit feeds it.
  assign digit_sel = (state_q == SHOW_C) ? tens_q : units_q;

  bcd_to_seg7 u_dec (
    .bcd_i (digit_sel),
    .seg_o (seg_dec)
  );

  // cnt_q runs across the whole slot: blank part first, then the show part.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    units_d = units_q;
    tens_d  = tens_q;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    fd_d    = 1'b0;

    if (!en) begin
      state_d = BLANK_U;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BLANK_U: begin
          if (cnt_q == '0) begin
            units_d = q_donvi;
            tens_d  = q_chuc;
          end
          if (cnt_q == BLANK_LAST) state_d = SHOW_U;
        end
        SHOW_U: begin
          an_d  = AN_UNITS;
          seg_d = seg_dec;
          if (cnt_q == CNT_LAST) begin
            state_d = BLANK_C;
            cnt_d   = '0;
          end
        end
        BLANK_C: begin
          if (cnt_q == BLANK_LAST) state_d = SHOW_C;
        end
        SHOW_C: begin
          if (!(LZ_BLANK != 0 && tens_q == 4'd0)) begin
            an_d  = AN_TENS;
            seg_d = seg_dec;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = BLANK_U;
            cnt_d   = '0;
            fd_d    = 1'b1;
          end
        end
        default: begin
          state_d = BLANK_U;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK_U;
      cnt_q   <= '0;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_m100.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a monitor compares on each falling edge.
module tb_seg7_scan_m100;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] q_donvi;
  logic [3:0] q_chuc;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  seg7_scan_m100 #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .LZ_BLANK  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .q_donvi    (q_donvi),
    .q_chuc     (q_chuc),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct {
    int         cyc;
    logic [1:0] an;
    logic [6:0] seg;
    logic       fd;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [1:0] a, input logic [6:0] s,
                      input logic f, input int t);
    exp_t e;
    e.cyc = c;
    e.an  = a;
    e.seg = s;
    e.fd  = f;
    e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic push_blank(input int c, input int t);
    push(c, 2'b11, 7'h7F, 1'b0, t);
  endtask

  // Frame starting at edge s (the latch edge): 2 blank, 6 units, 2 blank, 6 tens.
  task automatic push_frame(input int s, input logic [6:0] u, input logic [1:0] ca,
                            input logic [6:0] cs, input int n, input int t);
    for (int i = 0; i < n; i++) begin
      if (i < 2 || (i >= 8 && i < 10)) push_blank(s + i, t);
      else if (i < 8)                  push(s + i, 2'b10, u, 1'b0, t);
      else                             push(s + i, ca, cs, (i == 15), t);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.cyc != cyc || an !== e.an || seg !== e.seg || frame_done !== e.fd) begin
          errors++;
          $display("FAIL frame%0d cyc%0d (exp cyc%0d): got an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                   e.tag, cyc, e.cyc, an, seg, frame_done, e.an, e.seg, e.fd);
        end
      end
      if (done || cyc > 2000) begin
        checks++;
        if (!done || exp_q.size() != 0) begin
          errors++;
          $display("FAIL end_of_run: done=%0d pending=%0d, want done=1 pending=0",
                   done, exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    int s;
    rst = 1'b1;
    en = 1'b1;
    q_chuc = 4'd4;
    q_donvi = 4'd7;

    wait_cyc(2);
    push_blank(cyc + 1, 0);
    push_blank(cyc + 2, 0);
    s = cyc + 2;
    wait_cyc(s);
    rst = 1'b0;
    s = cyc + 1;

    // 47
    push_frame(s, 7'h78, 2'b01, 7'h19, 16, 1);
    wait_cyc(s);
    q_chuc = 4'd0; q_donvi = 4'd5;
    s += 16;
    // 05: tens blanked
    push_frame(s, 7'h12, 2'b11, 7'h7F, 16, 2);
    wait_cyc(s);
    q_chuc = 4'd0; q_donvi = 4'd0;
    s += 16;
    // 00: units still shown
    push_frame(s, 7'h40, 2'b11, 7'h7F, 16, 3);
    wait_cyc(s);
    q_chuc = 4'hA; q_donvi = 4'hF;
    s += 16;
    // non-BCD codes -> dashes
    push_frame(s, 7'h3F, 2'b01, 7'h3F, 16, 4);
    wait_cyc(s);
    q_chuc = 4'd3; q_donvi = 4'd9;
    s += 16;
    // 39, inputs move to 40 during SHOW_U: this frame must stay 39
    push_frame(s, 7'h10, 2'b01, 7'h30, 16, 5);
    wait_cyc(s + 4);
    q_chuc = 4'd4; q_donvi = 4'd0;
    s += 16;
    push_frame(s, 7'h40, 2'b01, 7'h19, 16, 6);
    s += 16;

    // en dropped for 5 edges during SHOW_C
    push_frame(s, 7'h40, 2'b01, 7'h19, 12, 7);
    for (int i = 12; i <= 16; i++) push_blank(s + i, 7);
    wait_cyc(s + 11);
    en = 1'b0;
    wait_cyc(s + 13);
    q_chuc = 4'd2; q_donvi = 4'd1;
    wait_cyc(s + 16);
    en = 1'b1;
    s += 17;
    push_frame(s, 7'h79, 2'b01, 7'h24, 16, 8);
    s += 16;

    // asynchronous reset between edges during SHOW_U
    push_frame(s, 7'h79, 2'b01, 7'h24, 5, 9);
    push_blank(s + 5, 9);
    push_blank(s + 6, 9);
    push_blank(s + 7, 9);
    wait_cyc(s + 4);
    @(posedge clk);
    #1 rst = 1'b1;
    q_chuc = 4'd8; q_donvi = 4'd9;
    wait_cyc(s + 7);
    rst = 1'b0;
    s = cyc + 1;
    push_frame(s, 7'h10, 2'b01, 7'h00, 16, 10);
    wait_cyc(s + 15);
    done = 1'b1;
  end

endmodule
